// File: rtl/alu_muldiv.sv
// Integer ALU with single-cycle logic/arith/shift ops and an iterative
// shift-add multiplier / restoring divider that writes the HI/LO pair.
module alu_muldiv #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4:0]             op,
  input  logic [DATA_WIDTH-1:0]  src1,
  input  logic [DATA_WIDTH-1:0]  src2,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  input  logic                   flush,
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  result,
  output logic                   ovf,
  output logic [DATA_WIDTH-1:0]  hi,
  output logic [DATA_WIDTH-1:0]  lo,
  output logic [1:0]             dbg_state
);

  localparam int W = DATA_WIDTH;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4;
  localparam logic [4:0] OP_NOR  = 5'd5;
  localparam logic [4:0] OP_SLT  = 5'd6;
  localparam logic [4:0] OP_SLL  = 5'd7;
  localparam logic [4:0] OP_SRL  = 5'd8;
  localparam logic [4:0] OP_SRA  = 5'd9;
  localparam logic [4:0] OP_SLTU = 5'd10;
  localparam logic [4:0] OP_MULT = 5'd11;
  localparam logic [4:0] OP_MULTU= 5'd12;
  localparam logic [4:0] OP_DIV  = 5'd13;
  localparam logic [4:0] OP_DIVU = 5'd14;
  localparam logic [4:0] OP_MFHI = 5'd15;
  localparam logic [4:0] OP_MFLO = 5'd16;
  localparam logic [4:0] OP_MTHI = 5'd17;
  localparam logic [4:0] OP_MTLO = 5'd18;

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, FIN = 2'd3} state_t;

  state_t state, state_nxt;

  logic [SHAMT_WIDTH-1:0] cnt;
  logic [2*W-1:0]         acc;      // {hi/remainder, lo/quotient} working register
  logic [W-1:0]           opb;      // multiplicand or divisor magnitude
  logic                   is_div;
  logic                   neg_lo;
  logic                   neg_hi;
  logic                   div_zero;
  logic [W-1:0]           src1_l;

  logic accept, is_mul_op, is_div_op, op_signed, last_iter;

  assign in_ready  = (state == IDLE);
  assign dbg_state = state;
  assign accept    = in_valid && in_ready && !flush;
  assign is_mul_op = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div_op = (op == OP_DIV)  || (op == OP_DIVU);
  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign last_iter = (cnt == SHAMT_WIDTH'(W - 1));

  // Single-cycle datapath
  logic [W-1:0] add_res, sub_res, alu_res;
  logic         add_ovf, sub_ovf, alu_ovf;

  assign add_res = src1 + src2;
  assign sub_res = src1 - src2;
  assign add_ovf = (src1[W-1] == src2[W-1]) && (add_res[W-1] != src1[W-1]);
  assign sub_ovf = (src1[W-1] != src2[W-1]) && (sub_res[W-1] != src1[W-1]);

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op)
      OP_ADD:  begin alu_res = add_res; alu_ovf = add_ovf; end
      OP_SUB:  begin alu_res = sub_res; alu_ovf = sub_ovf; end
      OP_AND:  alu_res = src1 & src2;
      OP_OR:   alu_res = src1 | src2;
      OP_XOR:  alu_res = src1 ^ src2;
      OP_NOR:  alu_res = ~(src1 | src2);
      OP_SLT:  alu_res = {{(W-1){1'b0}}, $signed(src1) < $signed(src2)};
      OP_SLL:  alu_res = src2 << shamt;
      OP_SRL:  alu_res = src2 >> shamt;
      OP_SRA:  alu_res = $signed(src2) >>> shamt;
      OP_SLTU: alu_res = {{(W-1){1'b0}}, src1 < src2};
      OP_MFHI: alu_res = hi;
      OP_MFLO: alu_res = lo;
      default: ;
    endcase
  end

  // Operand magnitudes; signed ops fix signs up in FIN
  logic [W-1:0] mag1, mag2;
  assign mag1 = (op_signed && src1[W-1]) ? -src1 : src1;
  assign mag2 = (op_signed && src2[W-1]) ? -src2 : src2;

  // One shift-add step and one restoring-division step
  logic [W:0]     mul_sum, div_shift, div_diff;
  logic [2*W-1:0] mul_next, div_next;

  assign mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opb} : {(W+1){1'b0}});
  assign mul_next  = {mul_sum, acc[W-1:1]};
  assign div_shift = acc[2*W-1:W-1];
  assign div_diff  = div_shift - {1'b0, opb};
  assign div_next  = div_diff[W] ? {acc[2*W-2:0], 1'b0}
                                 : {div_diff[W-1:0], acc[W-2:0], 1'b1};

  logic [2*W-1:0] prod_fin;
  logic [W-1:0]   quo, rem, fin_lo, fin_hi;

  assign prod_fin = neg_lo ? -acc : acc;
  assign quo      = acc[W-1:0];
  assign rem      = acc[2*W-1:W];
  assign fin_lo   = is_div ? (div_zero ? {W{1'b1}} : (neg_lo ? -quo : quo)) : prod_fin[W-1:0];
  assign fin_hi   = is_div ? (div_zero ? src1_l : (neg_hi ? -rem : rem)) : prod_fin[2*W-1:W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept && is_mul_op)      state_nxt = MUL;
          else if (accept && is_div_op) state_nxt = DIV;
        end
        MUL:     if (last_iter) state_nxt = FIN;
        DIV:     if (last_iter) state_nxt = FIN;
        FIN:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      acc       <= '0;
      opb       <= '0;
      is_div    <= 1'b0;
      neg_lo    <= 1'b0;
      neg_hi    <= 1'b0;
      div_zero  <= 1'b0;
      src1_l    <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      ovf       <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      out_valid <= 1'b0;
      if (flush) begin
        cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              cnt <= '0;
              if (is_mul_op) begin
                acc      <= {{W{1'b0}}, mag2};
                opb      <= mag1;
                is_div   <= 1'b0;
                neg_lo   <= op_signed && (src1[W-1] ^ src2[W-1]);
                neg_hi   <= op_signed && (src1[W-1] ^ src2[W-1]);
                div_zero <= 1'b0;
              end else if (is_div_op) begin
                acc      <= {{W{1'b0}}, mag1};
                opb      <= mag2;
                is_div   <= 1'b1;
                neg_lo   <= op_signed && (src1[W-1] ^ src2[W-1]);
                neg_hi   <= op_signed && src1[W-1];
                div_zero <= (src2 == '0);
                src1_l   <= src1;
              end else begin
                out_valid <= 1'b1;
                result    <= alu_res;
                ovf       <= alu_ovf;
                if (op == OP_MTHI) hi <= src1;
                if (op == OP_MTLO) lo <= src1;
              end
            end
          end
          MUL: begin
            acc <= mul_next;
            cnt <= cnt + SHAMT_WIDTH'(1);
          end
          DIV: begin
            acc <= div_next;
            cnt <= cnt + SHAMT_WIDTH'(1);
          end
          FIN: begin
            out_valid <= 1'b1;
            result    <= fin_lo;
            ovf       <= 1'b0;
            hi        <= fin_hi;
            lo        <= fin_lo;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv: arithmetic model with an expected-result
// queue, plus hand-computed literal checks on key vectors.
module tb_alu_muldiv;

  localparam int W = 32;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, flush, out_valid, ovf;
  logic [4:0]  op, shamt;
  logic [31:0] src1, src2, result, hi, lo;
  logic [1:0]  dbg_state;

  alu_muldiv #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .src1(src1), .src2(src2), .shamt(shamt), .flush(flush),
    .out_valid(out_valid), .result(result), .ovf(ovf), .hi(hi), .lo(lo),
    .dbg_state(dbg_state)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural model: {result, ovf, hi, lo} per completed operation
  logic [W-1:0] mhi = '0;
  logic [W-1:0] mlo = '0;
  logic [96:0]  exp_q[$];
  logic [96:0]  e;

  function automatic logic [96:0] model(input logic [4:0] o, input logic [31:0] a, b,
                                        input logic [4:0] sh);
    longint      sa, sb, s, q, r, t;
    logic [63:0] p;
    logic [31:0] res;
    logic        v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = '0;
    v = 1'b0;
    case (o)
      5'd0:  begin s = sa + sb; res = s[31:0]; v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      5'd1:  begin s = sa - sb; res = s[31:0]; v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      5'd2:  res = a & b;
      5'd3:  res = a | b;
      5'd4:  res = a ^ b;
      5'd5:  res = ~(a | b);
      5'd6:  res = {31'b0, sa < sb};
      5'd7:  res = b << sh;
      5'd8:  res = b >> sh;
      5'd9:  begin t = sb >>> sh; res = t[31:0]; end
      5'd10: res = {31'b0, a < b};
      5'd11: begin p = sa * sb; mhi = p[63:32]; mlo = p[31:0]; res = mlo; end
      5'd12: begin p = {32'b0, a} * {32'b0, b}; mhi = p[63:32]; mlo = p[31:0]; res = mlo; end
      5'd13: begin
        if (b == 0) begin mlo = '1; mhi = a; end
        else begin q = sa / sb; r = sa % sb; mlo = q[31:0]; mhi = r[31:0]; end
        res = mlo;
      end
      5'd14: begin
        if (b == 0) begin mlo = '1; mhi = a; end
        else begin mlo = a / b; mhi = a % b; end
        res = mlo;
      end
      5'd15: res = mhi;
      5'd16: res = mlo;
      5'd17: mhi = a;
      5'd18: mlo = a;
      default: ;
    endcase
    return {res, v, mhi, mlo};
  endfunction

  // Compare process: every out_valid must match the head of the queue
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_result", result, e[96:65]);
        check("sb_ovf", 32'(ovf), 32'(e[64]));
        check("sb_hi", hi, e[63:32]);
        check("sb_lo", lo, e[31:0]);
      end
    end
  end

  // Driver tasks
  task automatic issue(input logic [4:0] o, input logic [31:0] a, b, input logic [4:0] sh,
                       input bit track);
    in_valid = 1'b1;
    op = o; src1 = a; src2 = b; shamt = sh;
    @(posedge clk);
    if (track) exp_q.push_back(model(o, a, b, sh));
    #1;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
  endtask

  // Counts cycles from acceptance until out_valid, and busy (in_ready=0) cycles
  task automatic wait_done(output int cyc, output int busy);
    cyc = 1;
    busy = 0;
    while (!out_valid && cyc < 100) begin
      if (!in_ready) busy++;
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, busy;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
    op = '0; src1 = '0; src2 = '0; shamt = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Signed overflow on add
    issue(5'd0, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 1);
    check("add_ovf_valid", 32'(out_valid), 32'd1);
    check("add_ovf_result", result, 32'h8000_0000);
    check("add_ovf_flag", 32'(ovf), 32'd1);

    // Back-to-back single-cycle ops
    issue(5'd1, 32'h8000_0000, 32'h0000_0001, 5'd0, 1);
    issue(5'd1, 32'h0000_0005, 32'h0000_0007, 5'd0, 1);
    check("sub_wrap_result", result, 32'hFFFF_FFFE);
    issue(5'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0, 1);
    issue(5'd3, 32'hF000_0000, 32'h0000_000F, 5'd0, 1);
    issue(5'd4, 32'hAAAA_5555, 32'hFFFF_0000, 5'd0, 1);
    issue(5'd5, 32'h0F0F_0F0F, 32'h0000_FFFF, 5'd0, 1);
    issue(5'd6, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 1);
    check("slt_neg_result", result, 32'd1);
    issue(5'd10, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 1);
    check("sltu_result", result, 32'd0);
    issue(5'd7, 32'h0, 32'h8000_0001, 5'd31, 1);
    issue(5'd8, 32'h0, 32'h8000_0000, 5'd31, 1);
    issue(5'd9, 32'h0, 32'h8000_0000, 5'd31, 1);
    check("sra31_result", result, 32'hFFFF_FFFF);
    issue(5'd0, 32'h8000_0000, 32'h8000_0000, 5'd0, 1);

    // mthi then mfhi with no bubble
    issue(5'd17, 32'h1234_5678, 32'h0, 5'd0, 1);
    issue(5'd15, 32'h0, 32'h0, 5'd0, 1);
    check("mfhi_valid", 32'(out_valid), 32'd1);
    check("mfhi_result", result, 32'h1234_5678);
    issue(5'd18, 32'hCAFE_F00D, 32'h0, 5'd0, 1);
    issue(5'd16, 32'h0, 32'h0, 5'd0, 1);
    issue(5'd25, 32'h1111_1111, 32'h2222_2222, 5'd3, 1);
    check("illegal_result", result, 32'd0);
    check("illegal_hi", hi, 32'h1234_5678);
    idle_in();

    // Signed multiply; operand inputs are scrambled while it runs
    @(posedge clk); #1;
    issue(5'd11, 32'hFFFF_FFFE, 32'h0000_0003, 5'd0, 1);
    idle_in();
    op = 5'($urandom_range(0, 31)); src1 = $urandom(); src2 = $urandom();
    wait_done(cyc, busy);
    check("mult_busy_cycles", 32'(busy), 32'd33);
    check("mult_latency", 32'(cyc), 32'd34);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);

    issue(5'd13, 32'hFFFF_FFF9, 32'h0000_0002, 5'd0, 1);
    idle_in();
    wait_done(cyc, busy);
    check("div_latency", 32'(cyc), 32'd34);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    issue(5'd14, 32'h0000_0005, 32'h0000_0000, 5'd0, 1);
    idle_in();
    wait_done(cyc, busy);
    check("divu0_lo", lo, 32'hFFFF_FFFF);
    check("divu0_hi", hi, 32'h0000_0005);

    issue(5'd13, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 1);
    idle_in();
    wait_done(cyc, busy);
    check("div_minneg_lo", lo, 32'h8000_0000);
    check("div_minneg_hi", hi, 32'h0000_0000);

    issue(5'd13, 32'h0000_0064, 32'hFFFF_FFF9, 5'd0, 1);
    idle_in();
    wait_done(cyc, busy);
    issue(5'd13, 32'hFFFF_FFF0, 32'h0000_0000, 5'd0, 1);
    idle_in();
    wait_done(cyc, busy);
    check("div0_signed_hi", hi, 32'hFFFF_FFF0);
    issue(5'd12, 32'h0001_0003, 32'h0002_0005, 5'd0, 1);
    idle_in();
    wait_done(cyc, busy);

    issue(5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 1);
    idle_in();
    wait_done(cyc, busy);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);

    // Flush mid-multiply: no result, HI/LO retained
    issue(5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 0);
    idle_in();
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_in_ready", 32'(in_ready), 32'd1);
    check("flush_state", 32'(dbg_state), 32'd0);
    repeat (40) @(posedge clk);
    #1;
    check("flush_hi_kept", hi, 32'hFFFF_FFFE);
    check("flush_lo_kept", lo, 32'h0000_0001);

    // Flush in IDLE blocks the accept; the earlier result still appears
    issue(5'd2, 32'h0000_00FF, 32'h0000_0F0F, 5'd0, 1);
    flush = 1'b1;
    issue(5'd0, 32'h1, 32'h1, 5'd0, 0);
    flush = 1'b0;
    idle_in();
    check("flush_idle_no_accept", 32'(out_valid), 32'd0);

    // Reset during divide
    issue(5'd14, 32'd100, 32'd7, 5'd0, 0);
    idle_in();
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rstdiv_out_valid", 32'(out_valid), 32'd0);
    check("rstdiv_result", result, 32'd0);
    check("rstdiv_hi", hi, 32'd0);
    check("rstdiv_lo", lo, 32'd0);
    check("rstdiv_state", 32'(dbg_state), 32'd0);
    mhi = '0;
    mlo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    issue(5'd9, 32'h0, 32'h8000_0000, 5'd4, 1);
    idle_in();
    check("sra_after_rst", result, 32'hF800_0000);
    repeat (3) @(posedge clk);
    #1;

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
